mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port between the arbiter (master) and the memory/bus slave.
interface mem_port_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto one shared memory port; MEM has priority.
// Optional bus-wait timeout with sticky bus_err is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inst_ren,
    input  logic [31:0]         inst_addr,
    output logic [31:0]         inst_data,
    output logic                inst_rdy,
    input  logic                mem_ren,
    input  logic                mem_wen,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_dout,
    output logic [31:0]         mem_din,
    output logic                mem_rdy,
    output logic                if_stall,
    output logic                mem_stall,
    output logic                bus_err,
    mem_port_arbiter_if.master  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              owner_mem_q, owner_mem_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic [DATA_W-1:0] mem_din_q,   mem_din_d;
    logic              inst_rdy_q,  inst_rdy_d;
    logic              mem_rdy_q,   mem_rdy_d;
    logic              done;
    logic [DATA_W-1:0] rdata;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_mem_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
            inst_rdy_q  <= 1'b0;
            mem_rdy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
            inst_rdy_q  <= inst_rdy_d;
            mem_rdy_q   <= mem_rdy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        inst_rdy_d  = 1'b0;
        mem_rdy_d   = 1'b0;
        done        = 1'b0;
        rdata       = bus.bus_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (mem_ren || mem_wen) begin
                    owner_mem_d = 1'b1;
                    bus_we_d    = mem_wen;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_dout;
                    bus_req_d   = 1'b1;
                    state_d     = ST_BUSY;
                end else if (inst_ren) begin
                    owner_mem_d = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                    bus_req_d   = 1'b1;
                    state_d     = ST_BUSY;
                end
            end

            ST_BUSY: begin
                done = bus.bus_ack;
`ifdef ARB_TIMEOUT_EN
                // An ack in the limit cycle wins over the abort.
                if (!bus.bus_ack) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        done      = 1'b1;
                        rdata     = '1;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                if (done) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (owner_mem_q) begin
                        mem_rdy_d = 1'b1;
                        if (!bus_we_q) mem_din_d = rdata;
                    end else begin
                        inst_rdy_d  = 1'b1;
                        inst_data_d = rdata;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign inst_data = inst_data_q;
    assign mem_din   = mem_din_q;
    assign inst_rdy  = inst_rdy_q;
    assign mem_rdy   = mem_rdy_q;

    assign if_stall  = inst_ren & ~inst_rdy_q;
    assign mem_stall = (mem_ren | mem_wen) & ~mem_rdy_q;

`ifdef ARB_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    // No timeout hardware in this build; the limit parameter only folds into a constant.
    assign bus_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_rdy;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_rdy;
    logic        if_stall;
    logic        mem_stall;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .inst_rdy  (inst_rdy),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_rdy   (mem_rdy),
        .if_stall  (if_stall),
        .mem_stall (mem_stall),
        .bus_err   (bus_err),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ack(input logic a, input logic [31:0] d);
        bus_if.bus_ack   = a;
        bus_if.bus_rdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        inst_ren = 1'b0; inst_addr = '0;
        mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
        ack(1'b0, 32'h0);
        step(); step();
        check("rst bus_req",   32'(bus_if.bus_req), 32'd0);
        check("rst bus_we",    32'(bus_if.bus_we),  32'd0);
        check("rst bus_addr",  bus_if.bus_addr,     32'd0);
        check("rst bus_wdata", bus_if.bus_wdata,    32'd0);
        check("rst inst_data", inst_data,           32'd0);
        check("rst mem_din",   mem_din,             32'd0);
        check("rst rdy",       32'({inst_rdy, mem_rdy}), 32'd0);
        check("rst bus_err",   32'(bus_err),        32'd0);
        rst_n = 1'b1;
        step();

        // Single IF fetch, ack in first BUSY cycle
        inst_ren = 1'b1; inst_addr = 32'h0000_0010;
        step();
        check("if bus_req",  32'(bus_if.bus_req), 32'd1);
        check("if bus_addr", bus_if.bus_addr,     32'h10);
        check("if bus_we",   32'(bus_if.bus_we),  32'd0);
        check("if stall busy", 32'(if_stall),     32'd1);
        ack(1'b1, 32'h2008_0005);
        step();
        check("if inst_rdy",  32'(inst_rdy),  32'd1);
        check("if inst_data", inst_data,      32'h2008_0005);
        check("if stall rdy", 32'(if_stall),  32'd0);
        check("if bus_req resp", 32'(bus_if.bus_req), 32'd0);
        check("if mem_rdy",   32'(mem_rdy),   32'd0);
        inst_ren = 1'b0; ack(1'b0, 32'h0);
        step();
        check("if rdy one pulse", 32'(inst_rdy), 32'd0);

        // Ack outside BUSY is ignored
        ack(1'b1, 32'h9999_9999);
        step(); step();
        check("stray ack req", 32'(bus_if.bus_req), 32'd0);
        check("stray ack rdy", 32'({inst_rdy, mem_rdy}), 32'd0);
        check("stray ack data", inst_data, 32'h2008_0005);
        ack(1'b0, 32'h0);
        step();

        // Simultaneous requests: MEM first, then IF
        inst_ren = 1'b1; inst_addr = 32'h100;
        mem_ren = 1'b1;  mem_addr = 32'h40;
        step();
        check("prio bus_addr", bus_if.bus_addr, 32'h40);
        check("prio stalls", 32'({if_stall, mem_stall}), 32'd3);
        ack(1'b1, 32'h1111_2222);
        step();
        check("prio mem_rdy", 32'({inst_rdy, mem_rdy}), 32'd1);
        check("prio mem_din", mem_din, 32'h1111_2222);
        check("prio mem_stall", 32'(mem_stall), 32'd0);
        mem_ren = 1'b0; ack(1'b0, 32'h0);
        step();
        check("prio idle req", 32'(bus_if.bus_req), 32'd0);
        step();
        check("prio if bus_addr", bus_if.bus_addr, 32'h100);
        check("prio if bus_req", 32'(bus_if.bus_req), 32'd1);
        ack(1'b1, 32'h3333_4444);
        step();
        check("prio inst_rdy", 32'({inst_rdy, mem_rdy}), 32'd2);
        check("prio inst_data", inst_data, 32'h3333_4444);
        check("prio mem_din hold", mem_din, 32'h1111_2222);
        inst_ren = 1'b0; ack(1'b0, 32'h0);
        step();

        // Store with three wait cycles
        mem_wen = 1'b1; mem_addr = 32'h80; mem_dout = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr bus_req",   32'(bus_if.bus_req), 32'd1);
            check("wr bus_we",    32'(bus_if.bus_we),  32'd1);
            check("wr bus_wdata", bus_if.bus_wdata,    32'hDEAD_BEEF);
            check("wr bus_addr",  bus_if.bus_addr,     32'h80);
            check("wr no rdy",    32'(mem_rdy),        32'd0);
            if (i == 3) ack(1'b1, 32'hCAFE_F00D);
        end
        step();
        check("wr mem_rdy",  32'(mem_rdy), 32'd1);
        check("wr mem_din",  mem_din,      32'h1111_2222);
        check("wr req drop", 32'(bus_if.bus_req), 32'd0);
        mem_wen = 1'b0; ack(1'b0, 32'h0);
        step();
        check("wr rdy one pulse", 32'(mem_rdy), 32'd0);

        // Load and store asserted together is a write
        mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h84; mem_dout = 32'h0BAD_F00D;
        step();
        check("rw bus_we", 32'(bus_if.bus_we), 32'd1);
        ack(1'b1, 32'h7777_7777);
        step();
        check("rw mem_din", mem_din, 32'h1111_2222);
        mem_ren = 1'b0; mem_wen = 1'b0; ack(1'b0, 32'h0);
        step();

        // Request dropped mid-access still completes
        mem_ren = 1'b1; mem_addr = 32'h300;
        step();
        mem_ren = 1'b0;
        step();
        check("drop bus_req",  32'(bus_if.bus_req), 32'd1);
        check("drop stall",    32'(mem_stall),      32'd0);
        ack(1'b1, 32'h5555_AAAA);
        step();
        check("drop mem_rdy", 32'(mem_rdy), 32'd1);
        check("drop mem_din", mem_din,      32'h5555_AAAA);
        ack(1'b0, 32'h0);
        step();

        // Reset mid-BUSY abandons the access
        inst_ren = 1'b1; inst_addr = 32'h200;
        step();
        check("rstb bus_req pre", 32'(bus_if.bus_req), 32'd1);
        rst_n = 1'b0; inst_ren = 1'b0;
        #1;
        check("rstb bus_req",   32'(bus_if.bus_req), 32'd0);
        check("rstb bus_addr",  bus_if.bus_addr,     32'd0);
        check("rstb inst_data", inst_data,           32'd0);
        check("rstb mem_din",   mem_din,             32'd0);
        step();
        rst_n = 1'b1; ack(1'b1, 32'h4242_4242);
        step();
        check("rstb no rdy 1", 32'({inst_rdy, mem_rdy}), 32'd0);
        check("rstb req 1",    32'(bus_if.bus_req),      32'd0);
        step();
        check("rstb no rdy 2", 32'({inst_rdy, mem_rdy}), 32'd0);
        check("rstb data",     inst_data,                32'd0);
        ack(1'b0, 32'h0);
        step();

`ifdef ARB_TIMEOUT_EN
        // Ack in the limit cycle wins
        mem_ren = 1'b1; mem_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
            step();
            check("tow bus_req", 32'(bus_if.bus_req), 32'd1);
            if (i == 3) ack(1'b1, 32'h1234_5678);
        end
        step();
        check("tow mem_rdy", 32'(mem_rdy), 32'd1);
        check("tow mem_din", mem_din,      32'h1234_5678);
        check("tow bus_err", 32'(bus_err), 32'd0);
        mem_ren = 1'b0; ack(1'b0, 32'h0);
        step();

        // No ack: abort after four BUSY cycles
        mem_ren = 1'b1; mem_addr = 32'h404;
        for (int i = 0; i < 4; i++) begin
            step();
            check("to bus_req", 32'(bus_if.bus_req), 32'd1);
        end
        step();
        check("to req drop", 32'(bus_if.bus_req), 32'd0);
        check("to mem_rdy",  32'(mem_rdy),        32'd1);
        check("to mem_din",  mem_din,             32'hFFFF_FFFF);
        check("to bus_err",  32'(bus_err),        32'd1);
        mem_ren = 1'b0;
        step(); step();
        check("to bus_err sticky", 32'(bus_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("to bus_err rst", 32'(bus_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
`endif

        check("final bus_err", 32'(bus_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
